fmap_stream_serializer: RTL and testbench
=========================================

Name: fmap_stream_serializer

Overview:
- Consumes the flattened R*C feature map produced by the activation layer, where element i sits at bits [In_d_W*(i+1)-1 : In_d_W*i].
- Captures the map, then streams it one element per handshake in row-major order with row/col tags and a last flag.
- Sits between the activation stage and the element-serial consumers downstream (pooling, FC accumulate, output FIFO).

Parameters:
- In_d_W, 18, bit width of each element (two's complement).
- R, 3, feature-map rows; must be at least 1.
- C, 3, feature-map columns; must be at least 1.
- IDX_W, derived as max(1, $clog2(R*C)); not user-set.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- load_valid  in  1  X holds a complete map.
- load_ready  out  1  block can capture X this cycle.
- X  in  In_d_W*R*C  flattened input map.
- out_valid  out  1  out_data/out_row/out_col/out_last are valid.
- out_ready  in  1  downstream accepts the current element.
- out_data  out  In_d_W  current element.
- out_row  out  max(1,$clog2(R))  row of the current element.
- out_col  out  max(1,$clog2(C))  column of the current element.
- out_last  out  1  current element is the final beat of the map.
- busy  out  1  high while in STREAM.

Behaviour:
- Reset (clr=1 at an edge):
  - state goes to IDLE; index and map register are zeroed.
  - out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0.
  - load_ready is forced to 0 during any cycle in which clr=1.
  - clr asserted mid-stream aborts the map; no further beats for it.
- States:
  - IDLE: load_ready=1. On load_valid&&load_ready, register X, set idx to the first element to emit, go to STREAM.
  - STREAM: out_valid=1, busy=1. out_data is the slice of the map register at idx. out_row=idx/C, out_col=idx%C, both computed from counters, not division. out_last=1 iff idx is the final emitted index.
- Beat transfer: a beat transfers on out_valid&&out_ready.
  - Not last: advance idx to the next emitted index.
  - Last: return to IDLE.
- Back-to-back maps: load_ready=1 also during STREAM when out_last&&out_ready. A load in that same cycle captures the new X and stays in STREAM at the new map's first index, with no bubble.
- Latency: the first beat is valid in the cycle after the load handshake. Throughput is 1 element/cycle while out_ready=1.
- Stall: while out_ready=0, all outputs hold stable and the map register is unchanged.
- Input stability: X is sampled only on the load handshake; changes to X at other times are ignored.
- R*C=1: a single beat with out_last=1.
- No arithmetic: data passes through bit-exact, with no sign change.

Optional Feature:
- Macro: FMAP_SKIP_ZERO_EN.
- Defined:
  - Zero-valued elements (common after ReLU) are skipped; only nonzero elements are emitted, with their true row/col.
  - A nonzero mask is registered at load; the next index comes from a priority encoder over the remaining mask bits.
  - Element R*C-1 is always emitted, even if zero, so every map ends with exactly one out_last beat. An all-zero map emits one beat (row R-1, col C-1, data 0).
- Not defined: every element is emitted in order, and the mask logic is absent.

Decomposition:
- Package fmap_pkg:
  - state enum {IDLE, STREAM};
  - a function for IDX_W / row / col widths;
  - localparam N=R*C helper.
- One sub-module, fmap_next_idx: given the mask and the current idx, returns the next set index and an is_last flag. It is a combinational priority encoder, used only under FMAP_SKIP_ZERO_EN.

Test Plan:
- R=C=3, load X = elements 1..9, out_ready=1 → 9 beats on consecutive cycles, data 1..9; (row,col) goes (0,0)…(2,2); out_last only on the 9th beat; busy falls the next cycle.
- Stall: hold out_ready=0 for 3 cycles at beat 4 → data=4, row=1, col=0 held stable; no beat lost or duplicated.
- Back-to-back: present a second map (data 10..18) with load_valid during the last beat of the first → beat 10 follows beat 9 with no idle cycle; load_ready pulses exactly on that cycle.
- Reset mid-stream: clr=1 at beat 5 → next cycle out_valid=0 and all outputs 0; a new load afterwards restarts at (0,0).
- FMAP_SKIP_ZERO_EN, map {0,-3,0,0,7,0,0,0,0} → beats: -3 at (0,1), 7 at (1,1), 0 at (2,2) with out_last. An all-zero map → a single beat 0 at (2,2) with out_last.
- Negative value passthrough: element 0x20000 (18-bit -131072) is emitted unchanged.

Source files
------------

// File: rtl/fmap_pkg.sv
// Shared types and width helpers for the feature-map stream serializer.
package fmap_pkg;

  typedef enum logic {IDLE, STREAM} state_t;

  localparam int unsigned FMAP_IN_D_W = 18;
  localparam int unsigned FMAP_R      = 3;
  localparam int unsigned FMAP_C      = 3;
  localparam int unsigned FMAP_N      = FMAP_R * FMAP_C;

  // Index/field width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_next_idx.sv
// Priority encoder: next set mask bit after idx (or from 0 when start), with its row/col.
// Present only when FMAP_SKIP_ZERO_EN is defined.
`ifdef FMAP_SKIP_ZERO_EN
module fmap_next_idx #(
  parameter int unsigned R     = 3,
  parameter int unsigned C     = 3,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned RW    = 2,
  parameter int unsigned CW    = 2
) (
  input  logic [R*C-1:0]   mask,
  input  logic [IDX_W-1:0] idx,
  input  logic             start,
  output logic [IDX_W-1:0] next_idx_c,
  output logic [RW-1:0]    next_row_c,
  output logic [CW-1:0]    next_col_c,
  output logic             is_last_c
);

  logic found;

  // Row/col come from the loop counters, so no divider is inferred.
  always_comb begin
    found      = 1'b0;
    next_idx_c = IDX_W'(R*C - 1);
    next_row_c = RW'(R - 1);
    next_col_c = CW'(C - 1);
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned c = 0; c < C; c++) begin
        if (!found && mask[r*C + c] && (start || (IDX_W'(r*C + c) > idx))) begin
          found      = 1'b1;
          next_idx_c = IDX_W'(r*C + c);
          next_row_c = RW'(r);
          next_col_c = CW'(c);
        end
      end
    end
    is_last_c = (next_idx_c == IDX_W'(R*C - 1));
  end

endmodule
`endif

// File: rtl/fmap_stream_serializer.sv
// Captures a flattened R*C map and streams it row-major, one element per handshake.
// Optional FMAP_SKIP_ZERO_EN: skip zero elements (last element always emitted).
module fmap_stream_serializer
  import fmap_pkg::*;
#(
  parameter int unsigned In_d_W = FMAP_IN_D_W,
  parameter int unsigned R      = FMAP_R,
  parameter int unsigned C      = FMAP_C
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [In_d_W*R*C-1:0]         X,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [In_d_W-1:0]             out_data,
  output logic [clog2_min1(R)-1:0]      out_row,
  output logic [clog2_min1(C)-1:0]      out_col,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned N     = R * C;
  localparam int unsigned IDX_W = clog2_min1(N);
  localparam int unsigned RW    = clog2_min1(R);
  localparam int unsigned CW    = clog2_min1(C);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [In_d_W*N-1:0]  map;
  logic                 load_fire;
  logic                 beat_fire;

  logic [IDX_W-1:0]     first_idx, adv_idx;
  logic [RW-1:0]        first_row, adv_row;
  logic [CW-1:0]        first_col, adv_col;
  logic                 first_last, adv_last;
  logic [In_d_W-1:0]    first_data, adv_data;

  // Accept a map when idle, or on the final beat for a bubble-free follow-on.
  assign load_ready = !clr && ((state == IDLE) ||
                               ((state == STREAM) && out_last && out_ready));
  assign load_fire  = load_valid && load_ready;
  assign beat_fire  = out_valid && out_ready;

  assign first_data = X[first_idx*In_d_W +: In_d_W];
  assign adv_data   = map[adv_idx*In_d_W +: In_d_W];

`ifdef FMAP_SKIP_ZERO_EN
  logic [N-1:0] mask;
  logic [N-1:0] load_mask;

  // Last element is forced into the mask so every map ends with one last beat.
  always_comb begin
    load_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      load_mask[i] = (X[i*In_d_W +: In_d_W] != '0);
    end
    load_mask[N-1] = 1'b1;
  end

  fmap_next_idx #(.R(R), .C(C), .IDX_W(IDX_W), .RW(RW), .CW(CW)) u_first (
    .mask       (load_mask),
    .idx        ('0),
    .start      (1'b1),
    .next_idx_c (first_idx),
    .next_row_c (first_row),
    .next_col_c (first_col),
    .is_last_c  (first_last)
  );

  fmap_next_idx #(.R(R), .C(C), .IDX_W(IDX_W), .RW(RW), .CW(CW)) u_adv (
    .mask       (mask),
    .idx        (idx),
    .start      (1'b0),
    .next_idx_c (adv_idx),
    .next_row_c (adv_row),
    .next_col_c (adv_col),
    .is_last_c  (adv_last)
  );
`else
  assign first_idx  = '0;
  assign first_row  = '0;
  assign first_col  = '0;
  assign first_last = (N == 1);

  // Row/col counters step with the index; col wraps into the next row.
  always_comb begin
    adv_idx = idx + 1'b1;
    adv_row = out_row;
    adv_col = out_col + 1'b1;
    if (out_col == CW'(C - 1)) begin
      adv_col = '0;
      adv_row = out_row + 1'b1;
    end
    adv_last = (adv_idx == IDX_W'(N - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      idx       <= '0;
      map       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
`ifdef FMAP_SKIP_ZERO_EN
      mask      <= '0;
`endif
    end else if (load_fire) begin
      state     <= STREAM;
      map       <= X;
      idx       <= first_idx;
      out_valid <= 1'b1;
      busy      <= 1'b1;
      out_data  <= first_data;
      out_row   <= first_row;
      out_col   <= first_col;
      out_last  <= first_last;
`ifdef FMAP_SKIP_ZERO_EN
      mask      <= load_mask;
`endif
    end else if (beat_fire) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        idx      <= adv_idx;
        out_data <= adv_data;
        out_row  <= adv_row;
        out_col  <= adv_col;
        out_last <= adv_last;
      end
    end
  end

endmodule

// File: tb/tb_fmap_stream_serializer.sv
// Randomized self-checking bench for fmap_stream_serializer against a beat-list model.
module tb_fmap_stream_serializer;

  localparam int W = 18;
  localparam int R = 3;
  localparam int C = 3;
  localparam int N = R * C;
`ifdef FMAP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef logic [W*N-1:0] map_t;
  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   row;
    logic [1:0]   col;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         clr;
  logic         load_valid;
  logic         load_ready;
  map_t         X;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_row;
  logic [1:0]   out_col;
  logic         out_last;
  logic         busy;

  beat_t        act;
  beat_t        exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  assign act = {out_data, out_row, out_col, out_last};

  always #5 clk = ~clk;

  fmap_stream_serializer #(.In_d_W(W), .R(R), .C(C)) dut (
    .clk        (clk),
    .clr        (clr),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .X          (X),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy)
  );

  // Reference: list of emitted beats derived directly from the map contents.
  task automatic model_load(input map_t m);
    int    sel[$];
    beat_t b;
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      e = m[i*W +: W];
      if (!SKIP || e != '0 || i == N-1) sel.push_back(i);
    end
    foreach (sel[k]) begin
      b.data = m[sel[k]*W +: W];
      b.row  = 2'(sel[k] / C);
      b.col  = 2'(sel[k] % C);
      b.last = (k == sel.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic map_t seq_map(input int base);
    map_t m;
    for (int i = 0; i < N; i++) m[i*W +: W] = W'(base + i);
    return m;
  endfunction

  function automatic map_t rand_map(input bit allow_zero);
    map_t m;
    for (int i = 0; i < N; i++) begin
      if (allow_zero && $urandom_range(0, 2) == 0) m[i*W +: W] = '0;
      else m[i*W +: W] = W'($urandom_range(1, (1 << W) - 1));
    end
    return m;
  endfunction

  task automatic load_map(input map_t m);
    X = m;
    load_valid = 1'b1;
    model_load(m);
    @(posedge clk); #1;
    load_valid = 1'b0;
    X = rand_map(1'b0);
  endtask

  task automatic test_reset;
    clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_valid = 1'b1;
    X = rand_map(1'b0);
    #1;
    n_cmp++;
    if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_load_ready: got %b exp 0", load_ready);
    end
    n_cmp++;
    if ({out_valid, act, busy} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got v=%b beat=%h busy=%b exp all 0", out_valid, act, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_blocks_load: got out_valid=%b exp 0", out_valid);
    end
    clr = 1'b0;
    load_valid = 1'b0;
    #1;
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_load_ready: got %b exp 1", load_ready);
    end
  endtask

  task automatic test_basic;
    X = seq_map(1);
    load_valid = 1'b1;
    #1;
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_load_ready: got %b exp 1", load_ready);
    end
    load_valid = 1'b0;
    load_map(seq_map(1));
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || act !== exp_q[0]) begin
        n_err++; $display("FAIL basic_beat%0d: got v=%b busy=%b beat=%h exp %h", k, out_valid, busy, act, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_end_idle: got v=%b busy=%b exp 0/0", out_valid, busy);
    end
  endtask

  task automatic test_stall;
    int got = 0, stall = 0, cyc = 0;
    load_map(seq_map(1));
    while (got < N && cyc < 60) begin
      out_ready = (got == 3 && stall < 3) ? 1'b0 : 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || act !== exp_q[0] || load_ready !== (exp_q[0].last && out_ready)) begin
        n_err++; $display("FAIL stall_beat%0d: got v=%b beat=%h lr=%b exp %h", got, out_valid, act, load_ready, exp_q[0]);
      end
      if (out_ready) begin
        void'(exp_q.pop_front());
        got++;
      end else stall++;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (got != N || stall != 3 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_count: got beats=%0d stalls=%0d v=%b exp %0d/3/0", got, stall, out_valid, N);
    end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    load_map(seq_map(1));
    out_ready = 1'b1;
    while (got < 2*N) begin
      load_valid = 1'b0;
      if (got == N-1) begin
        X = seq_map(10);
        load_valid = 1'b1;
      end
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || act !== exp_q[0] || load_ready !== exp_q[0].last) begin
        n_err++; $display("FAIL b2b_beat%0d: got v=%b beat=%h lr=%b exp %h", got, out_valid, act, load_ready, exp_q[0]);
      end
      void'(exp_q.pop_front());
      if (load_valid) model_load(seq_map(10));
      got++;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_end_idle: got v=%b busy=%b exp 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid;
    int got = 0;
    load_map(seq_map(1));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    n_cmp++;
    if (act !== exp_q[0]) begin
      n_err++; $display("FAIL rstmid_beat5: got %h exp %h", act, exp_q[0]);
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL rstmid_load_ready: got %b exp 0", load_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
    n_cmp++;
    if ({out_valid, act, busy} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got v=%b beat=%h busy=%b exp all 0", out_valid, act, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_no_beats: got v=%b lr=%b exp 0/1", out_valid, load_ready);
    end
    load_map(seq_map(100));
    while (exp_q.size() > 0 && got < 20) begin
      n_cmp++;
      if (out_valid !== 1'b1 || act !== exp_q[0]) begin
        n_err++; $display("FAIL rstmid_reload%0d: got v=%b beat=%h exp %h", got, out_valid, act, exp_q[0]);
      end
      void'(exp_q.pop_front());
      got++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_negative;
    map_t m;
    int   got = 0;
    m = rand_map(1'b0);
    m[0 +: W] = 18'h20000;
    load_map(m);
    out_ready = 1'b1;
    n_cmp++;
    if (out_data !== 18'h20000) begin
      n_err++; $display("FAIL neg_passthrough: got %h exp 20000", out_data);
    end
    while (exp_q.size() > 0 && got < 20) begin
      n_cmp++;
      if (out_valid !== 1'b1 || act !== exp_q[0]) begin
        n_err++; $display("FAIL neg_beat%0d: got v=%b beat=%h exp %h", got, out_valid, act, exp_q[0]);
      end
      void'(exp_q.pop_front());
      got++;
      @(posedge clk); #1;
    end
  endtask

`ifdef FMAP_SKIP_ZERO_EN
  task automatic test_skip_zero;
    map_t         m;
    logic [W-1:0] ed [3];
    logic [1:0]   er [3];
    logic [1:0]   ec [3];
    m = '0;
    m[1*W +: W] = 18'h3FFFD;
    m[4*W +: W] = 18'd7;
    ed[0] = 18'h3FFFD; ed[1] = 18'd7; ed[2] = '0;
    er[0] = 2'd0; er[1] = 2'd1; er[2] = 2'd2;
    ec[0] = 2'd1; ec[1] = 2'd1; ec[2] = 2'd2;
    load_map(m);
    exp_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || act !== {ed[k], er[k], ec[k], (k == 2)}) begin
        n_err++; $display("FAIL skip_beat%0d: got v=%b beat=%h exp %h", k, out_valid, act, {ed[k], er[k], ec[k], (k == 2)});
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL skip_end: got v=%b exp 0", out_valid);
    end
    load_map('0);
    exp_q.delete();
    n_cmp++;
    if (out_valid !== 1'b1 || act !== {18'h0, 2'd2, 2'd2, 1'b1}) begin
      n_err++; $display("FAIL skip_allzero: got v=%b beat=%h exp %h", out_valid, act, {18'h0, 2'd2, 2'd2, 1'b1});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL skip_allzero_end: got v=%b exp 0", out_valid);
    end
  endtask
`endif

  task automatic test_random;
    int   maps_left = 25;
    int   cyc = 0;
    bit   do_load;
    map_t m;
    exp_q.delete();
    while ((maps_left > 0 || exp_q.size() > 0) && cyc < 5000) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      do_load    = 1'b0;
      if (exp_q.size() == 0) do_load = 1'b1;
      else if (exp_q[0].last && out_ready && maps_left > 0 && $urandom_range(0, 1) == 1) do_load = 1'b1;
      m = rand_map(1'b1);
      X = m;
      load_valid = do_load;
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
          n_err++; $display("FAIL rand_idle c%0d: got v=%b busy=%b lr=%b exp 0/0/1", cyc, out_valid, busy, load_ready);
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || act !== exp_q[0] ||
            load_ready !== (exp_q[0].last && out_ready)) begin
          n_err++; $display("FAIL rand_beat c%0d: got v=%b beat=%h lr=%b exp %h", cyc, out_valid, act, load_ready, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
      if (do_load) begin
        model_load(m);
        maps_left--;
      end
      @(posedge clk); #1;
      cyc++;
    end
    load_valid = 1'b0;
    n_cmp++;
    if (maps_left != 0 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rand_drain: got maps_left=%0d pending=%0d v=%b exp 0/0/0", maps_left, exp_q.size(), out_valid);
    end
  endtask

  initial begin
    clr        = 1'b1;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    X          = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_negative();
`ifdef FMAP_SKIP_ZERO_EN
    test_skip_zero();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
